uart_loop_fifo: RTL and testbench
=================================

UART_LOOP_FIFO -- requirements
Module: uart_loop_fifo

Interface
REQ-001 SHALL have parameter c_DEPTH, default 16: FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have parameter c_ADDR_W, default 4: pointer width, equal to log2(c_DEPTH).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port rx_dv, input, 1 bit: one-cycle pulse from the UART Rx; byte valid.
REQ-007 SHALL have port rx_byte, input, 8 bits: received byte, qualified by rx_dv.
REQ-008 SHALL have port tx_active, input, 1 bit: the UART Tx is serializing.
REQ-009 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the UART Tx; stop bit complete.
REQ-010 SHALL have port tx_dv, output, 1 bit: one-cycle launch pulse to the UART Tx.
REQ-011 SHALL have port tx_byte, output, 8 bits: byte to transmit; held from tx_dv until tx_done.
REQ-012 SHALL have port fifo_count, output, c_ADDR_W+1 bits: bytes stored, range 0..c_DEPTH.
REQ-013 SHALL have port empty, output, 1 bit: high when fifo_count == 0.
REQ-014 SHALL have port full, output, 1 bit: high when fifo_count == c_DEPTH.
REQ-015 SHALL have port overflow, output, 1 bit: sticky; a byte was dropped.

Function
REQ-016 SHALL store bytes in a c_DEPTH x 8 circular buffer with c_ADDR_W-bit write and read pointers.
REQ-017 SHALL make both pointers wrap from c_DEPTH-1 to 0 without any gap or stall.
REQ-018 SHALL write rx_byte at the write pointer and increment the write pointer on a rising edge where rx_dv=1 and the write is accepted.
REQ-019 SHALL accept the write when full=0, or when full=1 and a pop occurs on the same edge.
REQ-020 SHALL, for rx_dv=1 with full=1 and no same-edge pop: leave the buffer, pointers and count unchanged, and set overflow to 1.
REQ-021 SHALL hold overflow at 1 until rst.
REQ-022 SHALL implement a Tx-side FSM with three states: IDLE, LAUNCH, WAIT_DONE.
REQ-023 IDLE: if empty=0 and tx_active=0 -> load tx_byte from the head, pop (increment the read pointer), go to LAUNCH; otherwise stay in IDLE.
REQ-024 LAUNCH: tx_dv=1 for exactly this one cycle -> go to WAIT_DONE unconditionally.
REQ-025 WAIT_DONE: tx_dv=0 -> on tx_done=1 go to IDLE; otherwise stay.
REQ-026 SHALL make tx_dv and tx_byte registered outputs, with tx_byte stable from the LAUNCH cycle through the tx_done cycle.
REQ-027 SHALL give a latency from a write to an empty FIFO (idle Tx) to tx_dv=1 of exactly 2 rising edges: the write edge and the IDLE pop edge.
REQ-028 SHALL leave fifo_count unchanged on an edge with both an accepted write and a pop; otherwise +1 on a write and -1 on a pop.
REQ-029 SHALL never underflow: a pop occurs only in IDLE with empty=0.
REQ-030 SHALL make fifo_count, empty and full registered, and consistent with each other on every cycle.
REQ-031 SHALL ignore tx_done outside WAIT_DONE.
REQ-032 SHALL ignore rx_byte when rx_dv=0.
REQ-033 SHALL preserve byte order: bytes leave in the order they were accepted.

Reset
REQ-034 SHALL, on rst=1 asynchronously and mid-operation included: FSM=IDLE, pointers=0, fifo_count=0, empty=1, full=0, overflow=0, tx_dv=0, tx_byte=8'h00.
REQ-035 SHALL not clear buffer contents on reset; the contents are unobservable while empty=1.
REQ-036 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-037 Single byte: rx_dv with rx_byte=8'h3F, Tx idle -> tx_dv pulse 2 edges later with tx_byte=8'h3F; fifo_count 0->1->0; empty ends at 1.
REQ-038 Burst with Tx busy: tx_active=1, 16 writes 8'h00..8'h0F -> full=1, fifo_count=16, overflow=0; after release, tx_byte sequence 8'h00..8'h0F, one per tx_done.
REQ-039 Overflow: 17th write 8'hAA while full, no pop -> overflow=1, fifo_count stays 16, 8'hAA never transmitted; overflow stays 1 until rst.
REQ-040 Simultaneous write and pop at full: write 8'h55 on the IDLE pop edge -> fifo_count stays 16, overflow=0, 8'h55 transmitted last.
REQ-041 Wrap-around: 40 bytes streamed at the UART rate (c_CLKS_PER_BIT=87) -> output order identical, pointers wrap twice, count never above 1.
REQ-042 Reset mid-transfer: rst pulsed in WAIT_DONE with fifo_count=5 -> immediately tx_dv=0, fifo_count=0, empty=1; the next single write is transmitted correctly.

Source files
------------

// File: rtl/uart_loop_fifo_if.sv
// uart_loop_fifo_if: groups the UART-side handshake and FIFO status signals.
//   master : the UART side (drives rx_dv/rx_byte/tx_active/tx_done, sees the rest)
//   slave  : the loopback FIFO (drives tx_dv/tx_byte/fifo_count/empty/full/overflow)
interface uart_loop_fifo_if #(
    parameter int c_ADDR_W = 4
);
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              tx_active;
    logic              tx_done;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic [c_ADDR_W:0] fifo_count;
    logic              empty;
    logic              full;
    logic              overflow;

    modport master (
        output rx_dv, rx_byte, tx_active, tx_done,
        input  tx_dv, tx_byte, fifo_count, empty, full, overflow
    );

    modport slave (
        input  rx_dv, rx_byte, tx_active, tx_done,
        output tx_dv, tx_byte, fifo_count, empty, full, overflow
    );
endinterface

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: byte FIFO that loops UART Rx bytes back to a UART Tx.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : uart_loop_fifo_if.slave
//         in  rx_dv/rx_byte   received byte strobe and data
//         in  tx_active       Tx is serializing
//         in  tx_done         Tx stop-bit complete pulse
//         out tx_dv/tx_byte   launch pulse and held byte
//         out fifo_count/empty/full/overflow   registered status, overflow sticky
module uart_loop_fifo #(
    parameter int c_DEPTH  = 16,
    parameter int c_ADDR_W = 4
) (
    input logic             clk,
    input logic             rst,
    uart_loop_fifo_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

    localparam logic [c_ADDR_W:0] FullCount = (c_ADDR_W + 1)'(c_DEPTH);

    state_e              state;
    logic [7:0]          mem [c_DEPTH];
    logic [c_ADDR_W-1:0] wr_ptr;
    logic [c_ADDR_W-1:0] rd_ptr;
    logic [c_ADDR_W:0]   count;
    logic [c_ADDR_W:0]   count_nxt;
    logic                empty_r;
    logic                full_r;
    logic                overflow_r;
    logic                tx_dv_r;
    logic [7:0]          tx_byte_r;
    logic                pop;
    logic                wr_en;

    // A pop frees a slot on the same edge, so a write at full is still accepted then.
    assign pop   = (state == StIdle) && !empty_r && !bus.tx_active;
    assign wr_en = bus.rx_dv && (!full_r || pop);

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + (c_ADDR_W + 1)'(1);
        end else if (!wr_en && pop) begin
            count_nxt = count - (c_ADDR_W + 1)'(1);
        end
    end

    // Storage is deliberately not reset; contents are unobservable while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
        end else begin
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == FullCount);

            // Pointers are power-of-two wide, so +1 wraps with no special case.
            if (wr_en) begin
                wr_ptr <= wr_ptr + c_ADDR_W'(1);
            end
            if (bus.rx_dv && !wr_en) begin
                overflow_r <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    tx_dv_r <= 1'b0;
                    if (pop) begin
                        tx_byte_r <= mem[rd_ptr];
                        rd_ptr    <= rd_ptr + c_ADDR_W'(1);
                        tx_dv_r   <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    tx_dv_r <= 1'b0;
                    state   <= StWaitDone;
                end
                StWaitDone: begin
                    tx_dv_r <= 1'b0;
                    if (bus.tx_done) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    tx_dv_r <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

    assign bus.fifo_count = count;
    assign bus.empty      = empty_r;
    assign bus.full       = full_r;
    assign bus.overflow   = overflow_r;
    assign bus.tx_dv      = tx_dv_r;
    assign bus.tx_byte    = tx_byte_r;
endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: randomized loopback test against a queue-based reference model.
module tb_uart_loop_fifo;
    localparam int Depth = 16;
    localparam int AddrW = 4;

    logic clk;
    logic rst;

    uart_loop_fifo_if #(.c_ADDR_W(AddrW)) bus ();

    uart_loop_fifo #(
        .c_DEPTH (Depth),
        .c_ADDR_W(AddrW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted bytes plus the Tx-side phase
    // (0 free, 1 launch cycle, 2 waiting for tx_done).
    logic [7:0] m_q[$];
    int         m_phase;
    logic       m_ovf;
    logic [7:0] m_last;

    // Environment: UART Tx emulator and a forced-busy override.
    logic       hold;
    bit         emu_busy;
    int         emu_timer;
    int         emu_len_min;
    int         emu_len_max;

    int         max_cnt;
    logic [7:0] last_tx;
    bit         saw_aa;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_count", 32'(bus.fifo_count), 0);
        check_eq("rst_empty", 32'(bus.empty), 1);
        check_eq("rst_full", 32'(bus.full), 0);
        check_eq("rst_ovf", 32'(bus.overflow), 0);
        check_eq("rst_tx_dv", 32'(bus.tx_dv), 0);
        check_eq("rst_tx_byte", 32'(bus.tx_byte), 0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase   = 0;
        m_ovf     = 1'b0;
        emu_busy  = 1'b0;
        emu_timer = 0;
        bus.tx_done   = 1'b0;
        bus.tx_active = hold;
    endtask

    // One clock: capture inputs, advance, update model, compare, update environment.
    task automatic step();
        logic       s_dv;
        logic [7:0] s_byte;
        logic       s_act;
        logic       s_done;
        bit         pop;
        bit         acc;
        int         sz;
        s_dv   = bus.rx_dv;
        s_byte = bus.rx_byte;
        s_act  = bus.tx_active;
        s_done = bus.tx_done;
        sz     = m_q.size();
        pop    = (m_phase == 0) && (sz > 0) && !s_act;
        acc    = s_dv && ((sz < Depth) || pop);
        @(posedge clk);
        #1;
        if (pop) m_last = m_q.pop_front();
        if (acc) m_q.push_back(s_byte);
        if (s_dv && !acc) m_ovf = 1'b1;
        if (pop) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && s_done) m_phase = 0;

        check_eq("count", 32'(bus.fifo_count), 32'(m_q.size()));
        check_eq("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        check_eq("full", 32'(bus.full), 32'(m_q.size() == Depth));
        check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
        check_eq("tx_dv", 32'(bus.tx_dv), 32'(m_phase == 1));
        if (m_phase != 0) check_eq("tx_byte", 32'(bus.tx_byte), 32'(m_last));

        if (32'(bus.fifo_count) > max_cnt) max_cnt = 32'(bus.fifo_count);
        if (bus.tx_dv) begin
            last_tx = bus.tx_byte;
            if (bus.tx_byte == 8'hAA) saw_aa = 1'b1;
        end

        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'($urandom);
        bus.tx_done = 1'b0;
        if (emu_busy) begin
            emu_timer--;
            if (emu_timer <= 0) begin
                bus.tx_done = 1'b1;
                emu_busy    = 1'b0;
            end
        end
        if (bus.tx_dv) begin
            emu_busy  = 1'b1;
            emu_timer = $urandom_range(emu_len_max, emu_len_min);
        end
        bus.tx_active = hold | emu_busy;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        step();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((m_q.size() > 0 || m_phase != 0 || emu_busy) && n < limit) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 32'(n >= limit), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        hold          = 1'b0;
        bus.rx_dv     = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        emu_len_min   = 10;
        emu_len_max   = 20;
        max_cnt       = 0;
        last_tx       = 8'h00;
        saw_aa        = 1'b0;
        m_last        = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Single byte: launch two edges after the write.
        wr(8'h3F);
        check_eq("single_cnt1", 32'(bus.fifo_count), 1);
        check_eq("single_nodv", 32'(bus.tx_dv), 0);
        step();
        check_eq("single_dv", 32'(bus.tx_dv), 1);
        check_eq("single_byte", 32'(bus.tx_byte), 32'h3F);
        drain(200);
        check_eq("single_empty", 32'(bus.empty), 1);

        // Burst while Tx is busy, then overflow, then drain in order.
        hold = 1'b1;
        bus.tx_active = 1'b1;
        for (int i = 0; i < Depth; i++) wr(8'(i));
        check_eq("burst_full", 32'(bus.full), 1);
        check_eq("burst_count", 32'(bus.fifo_count), 16);
        check_eq("burst_ovf", 32'(bus.overflow), 0);
        saw_aa = 1'b0;
        wr(8'hAA);
        check_eq("ovf_set", 32'(bus.overflow), 1);
        check_eq("ovf_count", 32'(bus.fifo_count), 16);
        hold = 1'b0;
        bus.tx_active = emu_busy;
        drain(2000);
        check_eq("ovf_sticky", 32'(bus.overflow), 1);
        check_eq("aa_not_sent", 32'(saw_aa), 0);
        check_eq("burst_last", 32'(last_tx), 32'h0F);

        // Write at full on the pop edge.
        apply_reset();
        hold = 1'b1;
        bus.tx_active = 1'b1;
        for (int i = 0; i < Depth; i++) wr(8'($urandom_range(0, 8'h54)));
        hold = 1'b0;
        bus.tx_active = emu_busy;
        wr(8'h55);
        check_eq("simul_count", 32'(bus.fifo_count), 16);
        check_eq("simul_ovf", 32'(bus.overflow), 0);
        drain(2000);
        check_eq("simul_last", 32'(last_tx), 32'h55);

        // Streaming at UART rate: 40 bytes, pointers wrap twice.
        emu_len_min = 850;
        emu_len_max = 850;
        max_cnt     = 0;
        for (int i = 0; i < 40; i++) begin
            wr(8'($urandom));
            repeat (869) step();
        end
        drain(2000);
        check_eq("stream_max_le1", 32'(max_cnt <= 1), 1);

        // Reset in WAIT_DONE with five bytes queued.
        emu_len_min = 200;
        emu_len_max = 200;
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        step();
        check_eq("pre_rst_count", 32'(bus.fifo_count), 5);
        apply_reset();
        emu_len_min = 10;
        emu_len_max = 20;
        wr(8'hC3);
        drain(200);
        check_eq("post_rst_byte", 32'(last_tx), 32'hC3);

        // Random traffic with busy toggling and stray tx_done pulses.
        emu_len_min = 3;
        emu_len_max = 25;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) hold = ~hold;
            bus.tx_active = hold | emu_busy;
            if (!emu_busy && !bus.tx_done && $urandom_range(0, 19) == 0) bus.tx_done = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                bus.rx_dv   = 1'b1;
                bus.rx_byte = 8'($urandom);
            end
            step();
        end
        hold = 1'b0;
        bus.tx_active = emu_busy;
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
